// File: rtl/eq_pkg.sv
// Shared widths, FSM encoding and timing constants for the FIR equalizer band.
package eq_pkg;

  localparam int SAMPLE_W       = 24;
  localparam int COEF_W         = 16;
  localparam int PROD_W         = 40;
  localparam int COEF_ADDR_W    = 5;
  localparam int CYCLES_PER_TAP = 18;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUTPUT
  } state_t;

endpackage

// File: rtl/sample_delay_line.sv
// Circular buffer of the last N_TAPS samples with a combinational read at an
// offset back from the newest entry.
module sample_delay_line
  import eq_pkg::*;
#(
  parameter int N_TAPS = 8,
  localparam int PTR_W = $clog2(N_TAPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [SAMPLE_W-1:0] din,
  input  logic [PTR_W-1:0]    offset,
  output logic [SAMPLE_W-1:0] dout
);

  logic [SAMPLE_W-1:0] line [N_TAPS];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    newest;
  logic [PTR_W-1:0]    rd_idx;
  logic [PTR_W:0]      wrapped;

  // NOTE: the storage is reset on purpose; missing history must read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      for (int i = 0; i < N_TAPS; i++) line[i] <= '0;
    end else if (we) begin
      line[wr_ptr] <= din;
      wr_ptr       <= (wr_ptr == PTR_W'(N_TAPS - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

  // Extra bit keeps newest+N-offset exact for non-power-of-two depths.
  always_comb begin
    newest  = (wr_ptr == '0) ? PTR_W'(N_TAPS - 1) : wr_ptr - 1'b1;
    wrapped = {1'b0, newest} + (PTR_W + 1)'(N_TAPS) - {1'b0, offset};
    rd_idx  = (newest >= offset) ? newest - offset : wrapped[PTR_W-1:0];
    dout    = line[rd_idx];
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexes one shared multiplier across the taps of a FIR band and
// emits one scaled, saturated output per accepted sample.
module fir_tap_sequencer
  import eq_pkg::*;
#(
  parameter int N_TAPS = 8,
  parameter int SHIFT  = 15
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [SAMPLE_W-1:0]    i_sample,
  input  logic                   i_sample_valid,
  output logic                   o_sample_ready,
  output logic [SAMPLE_W-1:0]    o_out_sample,
  output logic                   o_out_valid,
  output logic                   o_out_sat,
  input  logic                   i_coef_we,
  input  logic [COEF_ADDR_W-1:0] i_coef_addr,
  input  logic [COEF_W-1:0]      i_coef_data,
  output logic                   o_coef_ack,
  output logic [SAMPLE_W-1:0]    o_mult_sample,
  output logic [COEF_W-1:0]      o_mult_coef,
  output logic                   o_mult_start,
  input  logic [PROD_W-1:0]      i_mult_product,
  input  logic                   i_mult_ready
);

  localparam int K_W   = $clog2(N_TAPS);
  localparam int ACC_W = PROD_W + K_W;

  state_t              state, next_state;
  logic [K_W-1:0]      k;
  logic [ACC_W-1:0]    acc, acc_sum, acc_shift;
  logic                wait_first;
  logic [COEF_W-1:0]   coef [N_TAPS];
  logic [SAMPLE_W-1:0] line_rd;
  logic                accept, coef_ok, tap_done, last_tap, clip, operands_on;

  sample_delay_line #(.N_TAPS(N_TAPS)) u_line (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .we     (accept),
    .din    (i_sample),
    .offset (k),
    .dout   (line_rd)
  );

  assign accept      = (state == IDLE) && i_sample_valid;
  assign coef_ok     = (state == IDLE) && i_coef_we &&
                       ({1'b0, i_coef_addr} < (COEF_ADDR_W + 1)'(N_TAPS));
  assign tap_done    = (state == WAIT) && !wait_first && i_mult_ready;
  assign last_tap    = (k == K_W'(N_TAPS - 1));
  assign acc_sum     = acc + ACC_W'(i_mult_product);
  assign acc_shift   = acc_sum >> SHIFT;
  assign clip        = |acc_shift[ACC_W-1:SAMPLE_W];
  assign operands_on = (state == ISSUE) || (state == WAIT);

  // Operands stay on the bus through WAIT so the multiplier may sample late.
  assign o_mult_sample = operands_on ? line_rd : '0;
  assign o_mult_coef   = operands_on ? coef[k] : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state     = state;
    o_sample_ready = 1'b0;
    o_mult_start   = 1'b0;
    o_out_valid    = 1'b0;
    unique case (state)
      IDLE: begin
        o_sample_ready = 1'b1;
        if (i_sample_valid) next_state = ISSUE;
      end
      ISSUE: begin
        o_mult_start = 1'b1;
        if (i_mult_ready) next_state = WAIT;
      end
      WAIT: begin
        if (tap_done) next_state = last_tap ? OUTPUT : ISSUE;
      end
      OUTPUT: begin
        o_out_valid = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      k            <= '0;
      acc          <= '0;
      wait_first   <= 1'b0;
      o_coef_ack   <= 1'b0;
      o_out_sample <= '0;
      o_out_sat    <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) coef[i] <= '0;
    end else begin
      o_coef_ack <= coef_ok;
      if (coef_ok) coef[i_coef_addr[K_W-1:0]] <= i_coef_data;
      // Ready is still high from the previous tap during the first WAIT cycle.
      wait_first <= (state == ISSUE);
      if (accept) begin
        acc <= '0;
        k   <= '0;
      end else if (tap_done) begin
        acc <= acc_sum;
        if (last_tap) begin
          o_out_sample <= clip ? '1 : acc_shift[SAMPLE_W-1:0];
          o_out_sat    <= clip;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

endmodule
